// File: rtl/ecc_scrub_pkg.sv
// ecc_scrub_pkg
// Shared types and constants for the ECC scrub scheduler:
//   - scrub_sched_state_e : scheduler FSM states
//   - DefaultIntervalWidth / DefaultTimeoutCycles : parameter defaults
//   - popcount16          : population count used by the error statistics
package ecc_scrub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        TRIG  = 2'd2,
        WAIT  = 2'd3
    } scrub_sched_state_e;

    localparam int unsigned DefaultIntervalWidth = 16;
    localparam int unsigned DefaultTimeoutCycles = 64;

    // Number of set bits in a vector of up to 16 banks (narrower vectors are zero-extended).
    function automatic logic [4:0] popcount16(input logic [15:0] vec);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ecc_scrub_rr_sel.sv
// ecc_scrub_rr_sel
// Round-robin bank selector: returns the first bank at or after ptr whose mask
// bit is set, wrapping from NumBanks-1 to 0.
// Ports:
//   mask     in  NumBanks  banks eligible for scrubbing
//   ptr      in  PtrWidth  round-robin start position
//   next_idx out PtrWidth  selected bank index (0 when nothing is eligible)
//   valid    out 1         at least one bank is eligible
module ecc_scrub_rr_sel #(
    parameter int unsigned NumBanks = 4,
    parameter int unsigned PtrWidth = 2
) (
    input  logic [NumBanks-1:0] mask,
    input  logic [PtrWidth-1:0] ptr,
    output logic [PtrWidth-1:0] next_idx,
    output logic                valid
);

    logic [2*NumBanks-1:0] rot_s;

    // Rotate the mask so bit 0 is the pointer position, then pick the lowest set offset.
    always_comb begin : sel_proc
        int sum;
        rot_s    = {mask, mask} >> ptr;
        next_idx = {PtrWidth{1'b0}};
        valid    = 1'b0;
        sum      = 0;
        // Walk offsets downward so the final assignment is the smallest offset.
        for (int k = int'(NumBanks) - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                valid = 1'b1;
                sum   = int'(ptr) + k;
                if (sum >= int'(NumBanks)) begin
                    sum = sum - int'(NumBanks);
                end else begin
                    sum = sum;
                end
                next_idx = PtrWidth'(sum);
            end else begin
                next_idx = next_idx;
            end
        end
    end

endmodule

// File: rtl/ecc_scrub_scheduler.sv
// ecc_scrub_scheduler
// Periodically triggers per-bank ECC scrubbers in round-robin order and keeps
// corrected / uncorrectable error statistics.
// Optional feature: define ECC_SCRUB_SCHED_TIMEOUT_EN to add a per-step watchdog
// that abandons a WAIT after TimeoutCycles cycles and pulses timeout_o.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   enable_i               scheduler enable
//   interval_i             idle cycles between scrub steps
//   bank_mask_i            per-bank scrub enable
//   scrub_trigger_o        one-hot trigger pulse (decoded from state and pointer)
//   scrub_done_i           per-bank scrubber-finished pulse
//   bit_corrected_i        per-bank corrected-error pulse
//   uncorrectable_i        per-bank uncorrectable-error pulse
//   clear_i                clears counters and the sticky IRQ
//   corr_cnt_o/uncorr_cnt_o saturating error totals
//   last_uncorr_bank_o     lowest bank index of the latest uncorrectable pulse
//   uncorr_irq_o           sticky uncorrectable flag
//   timeout_o              watchdog expiry pulse (0 without the watchdog)
//   busy_o                 high while in TRIG or WAIT
module ecc_scrub_scheduler
    import ecc_scrub_pkg::*;
#(
    parameter int unsigned NumBanks      = 4,
    parameter int unsigned IntervalWidth = DefaultIntervalWidth,
    parameter int unsigned CntWidth      = 16,
    parameter int unsigned TimeoutCycles = DefaultTimeoutCycles,
    localparam int unsigned PtrWidth     = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [IntervalWidth-1:0] interval_i,
    input  logic [NumBanks-1:0]      bank_mask_i,
    output logic [NumBanks-1:0]      scrub_trigger_o,
    input  logic [NumBanks-1:0]      scrub_done_i,
    input  logic [NumBanks-1:0]      bit_corrected_i,
    input  logic [NumBanks-1:0]      uncorrectable_i,
    input  logic                     clear_i,
    output logic [CntWidth-1:0]      corr_cnt_o,
    output logic [CntWidth-1:0]      uncorr_cnt_o,
    output logic [PtrWidth-1:0]      last_uncorr_bank_o,
    output logic                     uncorr_irq_o,
    output logic                     timeout_o,
    output logic                     busy_o
);

    scrub_sched_state_e state_r, state_next_s;
    logic [PtrWidth-1:0]      ptr_r, ptr_next_s, ptr_inc_s;
    logic [IntervalWidth-1:0] cnt_r, cnt_next_s;
    logic [PtrWidth-1:0]      sel_idx_s;
    logic                     sel_valid_s;
    logic                     mask_any_s;
    logic                     done_sel_s;
    logic                     wd_expire_s;
    logic                     busy_r;
    logic [CntWidth-1:0]      corr_cnt_r, uncorr_cnt_r;
    logic [PtrWidth-1:0]      last_uncorr_r, low_idx_s;
    logic                     irq_r;
    logic [4:0]               corr_pop_s, uncorr_pop_s;
    logic                     uncorr_any_s;

    // Saturating add of a popcount onto a statistics counter.
    function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] base,
                                                    input logic [4:0]          inc);
        logic [CntWidth+4:0] sum;
        sum = {5'd0, base} + {{CntWidth{1'b0}}, inc};
        if (sum > {5'd0, {CntWidth{1'b1}}}) begin
            return {CntWidth{1'b1}};
        end else begin
            return sum[CntWidth-1:0];
        end
    endfunction

    ecc_scrub_rr_sel #(
        .NumBanks (NumBanks),
        .PtrWidth (PtrWidth)
    ) u_rr_sel (
        .mask     (bank_mask_i),
        .ptr      (ptr_r),
        .next_idx (sel_idx_s),
        .valid    (sel_valid_s)
    );

    assign mask_any_s = |bank_mask_i;
    // Only the bank currently being scrubbed may end the step.
    assign done_sel_s = scrub_done_i[ptr_r];
    assign ptr_inc_s  = (ptr_r == PtrWidth'(NumBanks - 1)) ? {PtrWidth{1'b0}}
                                                           : ptr_r + PtrWidth'(1);

`ifdef ECC_SCRUB_SCHED_TIMEOUT_EN
    localparam int unsigned WdWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    logic [WdWidth-1:0] wd_r;
    logic               timeout_r;

    // Expiry on the TimeoutCycles-th WAIT cycle; a done in the same cycle takes precedence.
    assign wd_expire_s = (state_r == WAIT) && !done_sel_s &&
                         (wd_r == WdWidth'(TimeoutCycles - 1));

    // Watchdog counter (cleared outside WAIT) and registered expiry pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_r      <= {WdWidth{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= wd_expire_s;
            if ((state_r == WAIT) && !done_sel_s && !wd_expire_s) begin
                wd_r <= wd_r + WdWidth'(1);
            end else begin
                wd_r <= {WdWidth{1'b0}};
            end
        end
    end

    assign timeout_o = timeout_r;
`else
    assign wd_expire_s = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    // Next-state, pointer and interval-counter logic.
    always_comb begin
        state_next_s = state_r;
        ptr_next_s   = ptr_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (enable_i && mask_any_s) begin
                    state_next_s = COUNT;
                    cnt_next_s   = interval_i;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COUNT: begin
                if (!enable_i || !mask_any_s) begin
                    state_next_s = IDLE;
                end else if (cnt_r == {IntervalWidth{1'b0}}) begin
                    if (sel_valid_s) begin
                        // Pointer latches the chosen bank and stays frozen until WAIT ends.
                        state_next_s = TRIG;
                        ptr_next_s   = sel_idx_s;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r - IntervalWidth'(1);
                end
            end
            TRIG: begin
                state_next_s = WAIT;
            end
            WAIT: begin
                if (done_sel_s || wd_expire_s) begin
                    ptr_next_s = ptr_inc_s;
                    if (enable_i) begin
                        state_next_s = COUNT;
                        cnt_next_s   = interval_i;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Scheduler state registers; busy is registered from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            ptr_r   <= {PtrWidth{1'b0}};
            cnt_r   <= {IntervalWidth{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= (state_next_s == TRIG) || (state_next_s == WAIT);
        end
    end

    // One-hot trigger decoded from the TRIG state and the frozen pointer.
    always_comb begin
        scrub_trigger_o = {NumBanks{1'b0}};
        if (state_r == TRIG) begin
            scrub_trigger_o[ptr_r] = 1'b1;
        end else begin
            scrub_trigger_o = {NumBanks{1'b0}};
        end
    end

    assign corr_pop_s   = popcount16(16'(bit_corrected_i));
    assign uncorr_pop_s = popcount16(16'(uncorrectable_i));
    assign uncorr_any_s = |uncorrectable_i;

    // Lowest-index asserted uncorrectable bank (descending walk, last write wins).
    always_comb begin
        low_idx_s = {PtrWidth{1'b0}};
        for (int i = int'(NumBanks) - 1; i >= 0; i--) begin
            if (uncorrectable_i[i]) begin
                low_idx_s = PtrWidth'(i);
            end else begin
                low_idx_s = low_idx_s;
            end
        end
    end

    // Error statistics; a same-cycle increment wins over clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            corr_cnt_r    <= {CntWidth{1'b0}};
            uncorr_cnt_r  <= {CntWidth{1'b0}};
            last_uncorr_r <= {PtrWidth{1'b0}};
            irq_r         <= 1'b0;
        end else begin
            corr_cnt_r   <= sat_add(clear_i ? {CntWidth{1'b0}} : corr_cnt_r, corr_pop_s);
            uncorr_cnt_r <= sat_add(clear_i ? {CntWidth{1'b0}} : uncorr_cnt_r, uncorr_pop_s);
            irq_r        <= uncorr_any_s | (irq_r & ~clear_i);
            if (uncorr_any_s) begin
                last_uncorr_r <= low_idx_s;
            end else begin
                last_uncorr_r <= last_uncorr_r;
            end
        end
    end

    assign corr_cnt_o         = corr_cnt_r;
    assign uncorr_cnt_o       = uncorr_cnt_r;
    assign last_uncorr_bank_o = last_uncorr_r;
    assign uncorr_irq_o       = irq_r;
    assign busy_o             = busy_r;

endmodule

// File: tb/tb_ecc_scrub_scheduler.sv
// tb_ecc_scrub_scheduler
// Directed self-checking bench for ecc_scrub_scheduler (NumBanks=4, CntWidth=4).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled there too.
module tb_ecc_scrub_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       enable_i;
    logic [7:0] interval_i;
    logic [3:0] bank_mask_i;
    logic [3:0] scrub_trigger_o;
    logic [3:0] scrub_done_i;
    logic [3:0] bit_corrected_i;
    logic [3:0] uncorrectable_i;
    logic       clear_i;
    logic [3:0] corr_cnt_o;
    logic [3:0] uncorr_cnt_o;
    logic [1:0] last_uncorr_bank_o;
    logic       uncorr_irq_o;
    logic       timeout_o;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int trig_idx[8];
    int trig_cyc[8];
    int n_trig;

    ecc_scrub_scheduler #(
        .NumBanks      (4),
        .IntervalWidth (8),
        .CntWidth      (4),
        .TimeoutCycles (64)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .enable_i           (enable_i),
        .interval_i         (interval_i),
        .bank_mask_i        (bank_mask_i),
        .scrub_trigger_o    (scrub_trigger_o),
        .scrub_done_i       (scrub_done_i),
        .bit_corrected_i    (bit_corrected_i),
        .uncorrectable_i    (uncorrectable_i),
        .clear_i            (clear_i),
        .corr_cnt_o         (corr_cnt_o),
        .uncorr_cnt_o       (uncorr_cnt_o),
        .last_uncorr_bank_o (last_uncorr_bank_o),
        .uncorr_irq_o       (uncorr_irq_o),
        .timeout_o          (timeout_o),
        .busy_o             (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Wait (bounded) for a trigger; v=0 when the budget expires.
    task automatic wait_trig(input int budget, output logic [3:0] v, output int at);
        v  = 4'b0000;
        at = -1;
        for (int i = 0; i < budget && v == 4'b0000; i++) begin
            tick();
            if (scrub_trigger_o != 4'b0000) begin
                v  = scrub_trigger_o;
                at = cyc;
            end
        end
    endtask

    // Scrubber model: answers each trigger with done after done_delay cycles.
    // Returns on the cycle the last done is driven; caller clears scrub_done_i.
    task automatic run_scrubs(input int n, input int done_delay, input bit drop_en_last,
                              input int budget);
        int  cd;
        int  pend;
        int  idx;
        bit  act;
        n_trig = 0;
        act    = 1'b0;
        cd     = 0;
        pend   = 0;
        for (int c = 0; c < budget && (n_trig < n || act); c++) begin
            tick();
            scrub_done_i = 4'b0000;
            if (act) begin
                cd--;
                if (drop_en_last && n_trig == n && cd == 1) enable_i = 1'b0;
                if (cd == 0) begin
                    scrub_done_i = 4'b0001 << pend;
                    act = 1'b0;
                end
            end
            if (scrub_trigger_o != 4'b0000) begin
                idx = -1;
                for (int b = 0; b < 4; b++) begin
                    if (scrub_trigger_o[b]) idx = (idx == -1) ? b : -2;
                end
                if (n_trig < 8) begin
                    trig_idx[n_trig] = idx;
                    trig_cyc[n_trig] = cyc;
                end
                n_trig++;
                act  = 1'b1;
                cd   = done_delay;
                pend = (idx < 0) ? 0 : idx;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({scrub_trigger_o, corr_cnt_o, uncorr_cnt_o, last_uncorr_bank_o,
             uncorr_irq_o, timeout_o, busy_o} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got trig=%b corr=%0d uncorr=%0d last=%0d irq=%b to=%b busy=%b expected all 0",
                     scrub_trigger_o, corr_cnt_o, uncorr_cnt_o, last_uncorr_bank_o,
                     uncorr_irq_o, timeout_o, busy_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_round_robin();
        int e;
        int exp_idx[5] = '{0, 1, 2, 3, 0};
        int trig_seen;
        bank_mask_i = 4'b1111;
        interval_i  = 8'd3;
        enable_i    = 1'b1;
        e = cyc;
        run_scrubs(5, 2, 1'b1, 200);
        n_checks++;
        if (n_trig !== 5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d triggers expected 5", n_trig);
        end
        n_checks++;
        if (trig_cyc[0] - e !== 5) begin
            n_fail++;
            $display("FAIL rr_first_latency: got %0d expected 5", trig_cyc[0] - e);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (trig_idx[i] !== exp_idx[i]) begin
                n_fail++;
                $display("FAIL rr_idx[%0d]: got %0d expected %0d", i, trig_idx[i], exp_idx[i]);
            end
        end
        for (int i = 1; i < 5; i++) begin
            n_checks++;
            if (trig_cyc[i] - trig_cyc[i-1] !== 7) begin
                n_fail++;
                $display("FAIL rr_spacing[%0d]: got %0d expected 7", i, trig_cyc[i] - trig_cyc[i-1]);
            end
        end
        // enable dropped during the last WAIT: step completes, then IDLE
        tick();
        scrub_done_i = 4'b0000;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_busy: got %b expected 0", busy_o);
        end
        trig_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (scrub_trigger_o != 4'b0000) trig_seen++;
        end
        n_checks++;
        if (trig_seen !== 0) begin
            n_fail++;
            $display("FAIL disable_no_trigger: got %0d triggers expected 0", trig_seen);
        end
    endtask

    task automatic test_mask_skip();
        int exp_idx[4] = '{1, 3, 1, 3};
        int trig_seen;
        bank_mask_i = 4'b1010;
        interval_i  = 8'd1;
        enable_i    = 1'b1;
        run_scrubs(4, 2, 1'b0, 200);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (trig_idx[i] !== exp_idx[i]) begin
                n_fail++;
                $display("FAIL mask_idx[%0d]: got %0d expected %0d", i, trig_idx[i], exp_idx[i]);
            end
        end
        // now in COUNT: removing every bank must return to IDLE with no trigger
        tick();
        scrub_done_i = 4'b0000;
        bank_mask_i  = 4'b0000;
        trig_seen    = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (scrub_trigger_o != 4'b0000) trig_seen++;
        end
        n_checks++;
        if (trig_seen !== 0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_zero: got %0d triggers busy=%b expected 0 triggers busy=0",
                     trig_seen, busy_o);
        end
        enable_i = 1'b0;
    endtask

    task automatic test_done_filter();
        logic [3:0] v;
        int         at;
        int         trig_seen;
        bank_mask_i = 4'b0001;
        interval_i  = 8'd0;
        enable_i    = 1'b1;
        wait_trig(20, v, at);
        n_checks++;
        if (v !== 4'b0001) begin
            n_fail++;
            $display("FAIL filter_trigger: got %b expected 0001", v);
        end
        tick();
        scrub_done_i = 4'b1110;
        tick();
        tick();
        tick();
        n_checks++;
        if (busy_o !== 1'b1 || scrub_trigger_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL filter_other_done: got busy=%b trig=%b expected busy=1 trig=0000",
                     busy_o, scrub_trigger_o);
        end
        scrub_done_i = 4'b0001;
        enable_i     = 1'b0;
        tick();
        scrub_done_i = 4'b0000;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL filter_own_done: got busy=%b expected 0", busy_o);
        end
        trig_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (scrub_trigger_o != 4'b0000) trig_seen++;
        end
        n_checks++;
        if (trig_seen !== 0) begin
            n_fail++;
            $display("FAIL filter_idle: got %0d triggers expected 0", trig_seen);
        end
    endtask

    task automatic test_statistics();
        clear_i = 1'b1;
        tick();
        clear_i         = 1'b0;
        bit_corrected_i = 4'b0101;
        tick();
        bit_corrected_i = 4'b0000;
        n_checks++;
        if (corr_cnt_o !== 4'd2 || uncorr_cnt_o !== 4'd0) begin
            n_fail++;
            $display("FAIL stats_0101: got corr=%0d uncorr=%0d expected corr=2 uncorr=0",
                     corr_cnt_o, uncorr_cnt_o);
        end
        bit_corrected_i = 4'b1111;
        tick();
        bit_corrected_i = 4'b0000;
        n_checks++;
        if (corr_cnt_o !== 4'd6) begin
            n_fail++;
            $display("FAIL stats_1111: got %0d expected 6", corr_cnt_o);
        end
    endtask

    task automatic test_uncorr_clear();
        clear_i = 1'b1;
        tick();
        clear_i         = 1'b0;
        uncorrectable_i = 4'b1000;
        tick();
        uncorrectable_i = 4'b0000;
        n_checks++;
        if (uncorr_irq_o !== 1'b1 || last_uncorr_bank_o !== 2'd3 || uncorr_cnt_o !== 4'd1) begin
            n_fail++;
            $display("FAIL uncorr_bank3: got irq=%b last=%0d cnt=%0d expected irq=1 last=3 cnt=1",
                     uncorr_irq_o, last_uncorr_bank_o, uncorr_cnt_o);
        end
        uncorrectable_i = 4'b0110;
        tick();
        uncorrectable_i = 4'b0000;
        n_checks++;
        if (last_uncorr_bank_o !== 2'd1 || uncorr_cnt_o !== 4'd3) begin
            n_fail++;
            $display("FAIL uncorr_lowest: got last=%0d cnt=%0d expected last=1 cnt=3",
                     last_uncorr_bank_o, uncorr_cnt_o);
        end
        clear_i         = 1'b1;
        uncorrectable_i = 4'b0001;
        tick();
        clear_i         = 1'b0;
        uncorrectable_i = 4'b0000;
        n_checks++;
        if (uncorr_cnt_o !== 4'd1 || uncorr_irq_o !== 1'b1 || last_uncorr_bank_o !== 2'd0 ||
            corr_cnt_o !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_with_pulse: got cnt=%0d irq=%b last=%0d corr=%0d expected cnt=1 irq=1 last=0 corr=0",
                     uncorr_cnt_o, uncorr_irq_o, last_uncorr_bank_o, corr_cnt_o);
        end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        n_checks++;
        if (uncorr_cnt_o !== 4'd0 || uncorr_irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_alone: got cnt=%0d irq=%b expected cnt=0 irq=0",
                     uncorr_cnt_o, uncorr_irq_o);
        end
    endtask

    task automatic test_saturation();
        clear_i = 1'b1;
        tick();
        clear_i         = 1'b0;
        bit_corrected_i = 4'b0001;
        for (int i = 0; i < 20; i++) tick();
        bit_corrected_i = 4'b0000;
        n_checks++;
        if (corr_cnt_o !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_20_pulses: got %0d expected 15", corr_cnt_o);
        end
        clear_i = 1'b1;
        tick();
        clear_i         = 1'b0;
        bit_corrected_i = 4'b0011;
        for (int i = 0; i < 7; i++) tick();
        bit_corrected_i = 4'b0000;
        n_checks++;
        if (corr_cnt_o !== 4'd14) begin
            n_fail++;
            $display("FAIL sat_pre: got %0d expected 14", corr_cnt_o);
        end
        bit_corrected_i = 4'b1111;
        tick();
        bit_corrected_i = 4'b0000;
        n_checks++;
        if (corr_cnt_o !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_no_wrap: got %0d expected 15", corr_cnt_o);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] v;
        int         t0;
        bank_mask_i  = 4'b1111;
        interval_i   = 8'd0;
        scrub_done_i = 4'b0000;
        enable_i     = 1'b1;
        wait_trig(20, v, t0);
        n_checks++;
        if (v !== 4'b0010) begin
            n_fail++;
            $display("FAIL timeout_first_trigger: got %b expected 0010", v);
        end
`ifdef ECC_SCRUB_SCHED_TIMEOUT_EN
        begin
            int         tc;
            int         pulses;
            int         t2;
            logic [3:0] v2;
            tc     = -1;
            pulses = 0;
            t2     = -1;
            v2     = 4'b0000;
            for (int i = 0; i < 80 && v2 == 4'b0000; i++) begin
                tick();
                if (timeout_o) begin
                    pulses++;
                    if (tc < 0) tc = cyc;
                end
                if (scrub_trigger_o != 4'b0000) begin
                    v2 = scrub_trigger_o;
                    t2 = cyc;
                end
            end
            n_checks++;
            if (tc - t0 !== 65 || pulses !== 1) begin
                n_fail++;
                $display("FAIL timeout_pulse: got offset=%0d pulses=%0d expected offset=65 pulses=1",
                         tc - t0, pulses);
            end
            n_checks++;
            if (v2 !== 4'b0100 || t2 - t0 !== 66) begin
                n_fail++;
                $display("FAIL timeout_next_bank: got %b at +%0d expected 0100 at +66", v2, t2 - t0);
            end
            enable_i = 1'b0;
            tick();
            scrub_done_i = 4'b0100;
            tick();
            scrub_done_i = 4'b0000;
        end
`else
        begin
            int to_seen;
            int trig_seen;
            to_seen   = 0;
            trig_seen = 0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (timeout_o) to_seen++;
                if (scrub_trigger_o != 4'b0000) trig_seen++;
            end
            n_checks++;
            if (to_seen !== 0 || trig_seen !== 0 || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL no_watchdog_wait: got timeouts=%0d triggers=%0d busy=%b expected 0 0 1",
                         to_seen, trig_seen, busy_o);
            end
            enable_i     = 1'b0;
            scrub_done_i = 4'b0010;
            tick();
            scrub_done_i = 4'b0000;
        end
`endif
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_end_busy: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [3:0] v;
        int         at;
        int         e;
        int         trig_seen;
        bit_corrected_i = 4'b0001;
        uncorrectable_i = 4'b0100;
        tick();
        bit_corrected_i = 4'b0000;
        uncorrectable_i = 4'b0000;
        bank_mask_i     = 4'b1111;
        interval_i      = 8'd0;
        enable_i        = 1'b1;
        wait_trig(20, v, at);
        tick();
        rst_i    = 1'b1;
        enable_i = 1'b0;
        tick();
        rst_i = 1'b0;
        n_checks++;
        if ({scrub_trigger_o, corr_cnt_o, uncorr_cnt_o, last_uncorr_bank_o,
             uncorr_irq_o, timeout_o, busy_o} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_in_wait: got trig=%b corr=%0d uncorr=%0d last=%0d irq=%b to=%b busy=%b expected all 0",
                     scrub_trigger_o, corr_cnt_o, uncorr_cnt_o, last_uncorr_bank_o,
                     uncorr_irq_o, timeout_o, busy_o);
        end
        trig_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (scrub_trigger_o != 4'b0000) trig_seen++;
        end
        n_checks++;
        if (trig_seen !== 0) begin
            n_fail++;
            $display("FAIL reset_no_reissue: got %0d triggers expected 0", trig_seen);
        end
        // pointer restarts at bank 0; interval 0 gives a single COUNT cycle
        enable_i = 1'b1;
        e = cyc;
        wait_trig(20, v, at);
        n_checks++;
        if (v !== 4'b0001 || at - e !== 2) begin
            n_fail++;
            $display("FAIL reset_ptr_restart: got %b at +%0d expected 0001 at +2", v, at - e);
        end
        enable_i = 1'b0;
        tick();
        scrub_done_i = 4'b0001;
        tick();
        scrub_done_i = 4'b0000;
    endtask

    initial begin
        rst_i           = 1'b1;
        enable_i        = 1'b0;
        interval_i      = 8'd0;
        bank_mask_i     = 4'b0000;
        scrub_done_i    = 4'b0000;
        bit_corrected_i = 4'b0000;
        uncorrectable_i = 4'b0000;
        clear_i         = 1'b0;
        test_reset();
        test_round_robin();
        test_mask_skip();
        test_done_filter();
        test_statistics();
        test_uncorr_clear();
        test_saturation();
        test_timeout();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_scrub_scheduler.md
ECC_SCRUB_SCHEDULER -- requirements
Module: ecc_scrub_scheduler

Interface
REQ-001 SHALL have parameter NumBanks, default 4, the number of scrubbed cache banks (1..16).
REQ-002 SHALL have parameter IntervalWidth, default 16, the width of the scrub-interval counter.
REQ-003 SHALL have parameter CntWidth, default 16, the width of the error-statistics counters.
REQ-004 SHALL have parameter TimeoutCycles, default 64, the watchdog limit in cycles per scrub step.
REQ-005 SHALL have ports:
- clk_i  in  1  the single clock.
- rst_i  in  1  reset; synchronous and active-high.
- enable_i  in  1  scheduler enable.
- interval_i  in  IntervalWidth  idle cycles between scrub steps.
- bank_mask_i  in  NumBanks  per-bank scrub enable.
- scrub_trigger_o  in/out: out  NumBanks  one-hot per-bank trigger pulse.
- scrub_done_i  in  NumBanks  per-bank pulse: scrubber returned to idle.
- bit_corrected_i  in  NumBanks  per-bank corrected pulse.
- uncorrectable_i  in  NumBanks  per-bank uncorrectable pulse.
- clear_i  in  1  clears statistics and the sticky IRQ.
- corr_cnt_o  out  CntWidth  total corrected errors.
- uncorr_cnt_o  out  CntWidth  total uncorrectable errors.
- last_uncorr_bank_o  out  $clog2(NumBanks) (min 1)  bank index of the latest uncorrectable error.
- uncorr_irq_o  out  1  sticky uncorrectable flag.
- timeout_o  out  1  one-cycle pulse on watchdog expiry.
- busy_o  out  1  high in TRIG or WAIT.

Function
REQ-006 FSM states SHALL be IDLE, COUNT, TRIG, WAIT.
REQ-007 IDLE SHALL go to COUNT with the interval counter loaded to interval_i when enable_i=1 and bank_mask_i!=0.
REQ-008 COUNT SHALL decrement each cycle and go to TRIG on the cycle the counter is 0.
- interval_i=0 SHALL give exactly one COUNT cycle.
REQ-009 TRIG SHALL last one cycle.
- It SHALL assert scrub_trigger_o[ptr] for that cycle only, then go to WAIT.
- ptr is the next bank, at or after the round-robin pointer, with bank_mask_i set, wrapping from NumBanks-1 to 0.
REQ-010 WAIT SHALL end when scrub_done_i[ptr]=1.
- The pointer SHALL advance to ptr+1 (mod NumBanks).
- The FSM SHALL go to COUNT (counter reloaded) if enable_i=1, else to IDLE.
REQ-011 scrub_done_i from banks other than ptr SHALL be ignored.
REQ-012 bit_corrected_i and uncorrectable_i SHALL be counted from all banks in any state.
- Each counter SHALL add the popcount of its input vector each cycle.
- Each counter SHALL saturate at all-ones.
REQ-013 On an uncorrectable pulse:
- uncorr_irq_o SHALL set.
- last_uncorr_bank_o SHALL capture the lowest-index asserted bank.
REQ-014 clear_i SHALL zero both counters and uncorr_irq_o.
- Increments in the same cycle SHALL win: the counter loads the popcount and the IRQ sets.
REQ-015 enable_i deasserting in COUNT SHALL return to IDLE next cycle.
- In TRIG or WAIT the step SHALL complete first; a scrub in flight is never abandoned.
REQ-016 If bank_mask_i becomes 0 in COUNT, the FSM SHALL go to IDLE without triggering.
REQ-017 ptr SHALL be frozen between TRIG and the end of WAIT; a mask change SHALL take effect at the next TRIG.
REQ-018 All outputs SHALL be registered except scrub_trigger_o, which is decoded from the state and ptr.

Reset
REQ-019 On rst_i=1 at a clock edge, the block SHALL go to IDLE with the following values:
- ptr=0, interval counter=0.
- corr_cnt_o=0, uncorr_cnt_o=0, last_uncorr_bank_o=0.
- uncorr_irq_o=0, timeout_o=0, busy_o=0, scrub_trigger_o=0.
REQ-020 Reset mid-WAIT SHALL abandon the step with no trigger reissued; the bank's scrubber is reset by the same reset.

Configuration
REQ-021 With ECC_SCRUB_SCHED_TIMEOUT_EN defined, a watchdog SHALL count WAIT cycles.
- After TimeoutCycles cycles without done, the block SHALL pulse timeout_o, advance ptr, and leave WAIT as in REQ-010.
REQ-022 Without ECC_SCRUB_SCHED_TIMEOUT_EN:
- There SHALL be no watchdog logic.
- timeout_o SHALL be tied to 0.
- WAIT SHALL persist until done.

Structure
REQ-023 Package ecc_scrub_pkg SHALL hold:
- the scrub_sched_state_e enum.
- the default-interval and default-timeout localparams.
REQ-024 Round-robin next-bank selection SHALL be sub-module ecc_scrub_rr_sel (mask, ptr -> next index, valid).

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Round robin: NumBanks=4, mask=4'b1111, interval=3, done 2 cycles after each trigger -> triggers to banks 0,1,2,3,0, spaced 3+1+1+2 cycles apart.
- Mask skip: mask=4'b1010 -> triggers alternate between bank 1 and bank 3 only; mask=0 in COUNT -> IDLE, no trigger.
- Statistics: bit_corrected_i=4'b0101 on one cycle -> corr_cnt_o increments by 2.
- Uncorrectable and clear: uncorrectable_i=4'b1000 -> uncorr_irq_o=1, last_uncorr_bank_o=3; clear_i together with a new pulse -> uncorr_cnt_o=1, IRQ stays 1.
- Saturation and timeout: CntWidth=4, 20 corrected pulses -> corr_cnt_o=15. With the macro defined, done withheld -> timeout_o pulses after 64 WAIT cycles and the next bank is triggered.
- Disable and reset: enable_i dropped in WAIT -> step completes, then IDLE. rst_i asserted in WAIT -> all outputs 0 next cycle, no trigger.
